mcp_main_control: RTL and testbench
===================================

Name: mcp_main_control

Overview:
- Moore finite state machine that sequences the multicycle MIPS datapath through fetch, decode, execute, memory and writeback.
- Drives every datapath control line, including pc_write and pc_write_cond.
- The PC-enable OR gate, located in the datapath, combines these two as pc_write | (pc_write_cond & zero).
- One instruction is processed per pass through the state graph.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load-word opcode
- OP_SW, 6'b101011, store-word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- opcode  in  6  instr[31:26] from the instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if the ALU zero flag is set
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- ir_write  out  1  instruction register load
- pc_source  out  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = use funct field
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B select: 00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- reg_write  out  1  register file write
- reg_dst  out  1  destination register select: 0 = rt, 1 = rd
- instr_done  out  1  one-cycle pulse in the last state of each instruction
- illegal_op  out  1  sticky flag for an unknown opcode
- state_dbg  out  4  current state encoding

Behaviour:
- Reset:
  - Clock and reset: one clock; reset is asynchronous and active-high.
  - rst forces state to IDLE and clears illegal_op.
  - In IDLE all control outputs are 0 and state_dbg = 4'd10.
- Outputs are pure Moore decodes of the state register. They have no combinational path from opcode, which is sampled only in DECODE.
- States (encoding); any output not listed is 0:
  - IDLE (10): next FETCH unconditionally.
  - FETCH (0): mem_read, ir_write, alu_src_b=01, pc_write, pc_source=00. Next DECODE.
  - DECODE (1): alu_src_b=11. Next state by opcode:
    - LW or SW → MEMADR
    - RTYPE → EXEC
    - BEQ → BRANCH
    - J → JUMP
    - any other opcode → FETCH, and illegal_op is set.
  - MEMADR (2): alu_src_a=1, alu_src_b=10. Next MEMRD for LW, MEMWR for SW. The opcode is still held in the IR here.
  - MEMRD (3): mem_read, i_or_d. Next MEMWB.
  - MEMWB (4): reg_write, mem_to_reg, reg_dst=0, instr_done. Next FETCH.
  - MEMWR (5): mem_write, i_or_d, instr_done. Next FETCH.
  - EXEC (6): alu_src_a=1, alu_op=10. Next RTYPEWB.
  - RTYPEWB (7): reg_write, reg_dst=1, instr_done. Next FETCH.
  - BRANCH (8): alu_src_a=1, alu_op=01, pc_write_cond, pc_source=01, instr_done. Next FETCH.
  - JUMP (9): pc_write, pc_source=10, instr_done. Next FETCH.
  - Unused encodings 11–15: all outputs 0, next FETCH (self-recovery).
- Latency in cycles, FETCH through the final state: LW 5, SW 4, R-type 4, BEQ 3, J 3.
- Only the illegal-opcode path leaves DECODE without asserting instr_done.
- Mutual exclusion invariants:
  - mem_read and mem_write never both high.
  - pc_write and pc_write_cond never both high.
  - reg_write is high only in MEMWB or RTYPEWB.
- illegal_op stays set until rst; it does not halt sequencing.
- rst mid-instruction: the FSM returns to IDLE immediately (asynchronously), all strobes drop in the same cycle, and no partial writeback occurs.

Decomposition:
- Package mcp_ctrl_pkg holds:
  - state encodings, as a localparam or enum
  - opcode constants
  - alu_op, pc_source and alu_src_b codes.
- One natural sub-module: mcp_ctrl_decode, the combinational state → control-word decoder. It keeps the top level to the state register, next-state logic and the illegal_op flag.

Test Plan:
- Reset and startup: assert rst mid-cycle, release; opcode=6'b100011 held → state_dbg sequence 10, 0, 1, 2, 3, 4, 0; instr_done high only in state 4; reg_write=1 and mem_to_reg=1 in state 4.
- SW: opcode=6'b101011 → states 0, 1, 2, 5; mem_write=1 and i_or_d=1 in state 5; reg_write never asserted.
- R-type then BEQ back to back: opcode 000000 then 000100 → states 0, 1, 6, 7, 0, 1, 8; alu_op=10 in state 6; state 8 shows pc_write_cond=1, pc_source=01, alu_op=01.
- Jump: opcode=6'b000010 → states 0, 1, 9; pc_write=1 and pc_source=10 in state 9; returns to 0.
- Illegal opcode 6'b111111 → DECODE goes directly to FETCH; illegal_op goes to 1 and remains set through a following legal LW; instr_done is not pulsed for the illegal instruction.
- Reset during MEMRD: rst asserted while state_dbg=3 → all outputs 0 in the same cycle (asynchronous); after release the sequence restarts 10, 0.
- Apply the mutual exclusion invariants as concurrent assertions across all of the scenarios above.

Source files
------------

// File: rtl/mcp_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: states, opcodes,
// datapath select codes and the packed control word.
package mcp_ctrl_pkg;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXEC    = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_JUMP    = 4'd9;
  localparam logic [3:0] S_IDLE    = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_legal_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mcp_ctrl_decode.sv
// Pure state -> control-word decoder; no opcode input so outputs stay Moore.
module mcp_ctrl_decode
  import mcp_ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCS_ALU;
      end
      S_DECODE: ctrl_o.alu_src_b = SRCB_IMM_SH;
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.i_or_d     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_RTYPEWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCS_ALUOUT;
        ctrl_o.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_source  = PCS_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mcp_main_control.sv
// Multicycle MIPS main controller: state register, next-state logic and the
// sticky illegal-opcode flag; outputs come from mcp_ctrl_decode.
module mcp_main_control
  import mcp_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic [1:0] pc_source,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  logic [3:0] state_q, state_d;
  logic       ill_q, ill_d;
  ctrl_t      ctrl;

  always_comb begin
    state_d = S_FETCH;
    ill_d   = ill_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
        if (!is_legal_op(opcode)) ill_d = 1'b1;
      end
      // IR still holds the memory opcode here; anything but SW is a load
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RTYPEWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ill_q   <= ill_d;
    end
  end

  mcp_ctrl_decode u_decode (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign ir_write      = ctrl.ir_write;
  assign pc_source     = ctrl.pc_source;
  assign alu_op        = ctrl.alu_op;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign instr_done    = ctrl.instr_done;
  assign illegal_op    = ill_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mcp_main_control.sv
// Directed bench for mcp_main_control: expected state/flag pairs are queued
// per instruction and compared each falling edge against a table model.
module tb_mcp_main_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'b100011;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst;
  logic       instr_done, illegal_op;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic [3:0] state_dbg;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] st;
    logic       ill;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mcp_main_control dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .pc_source(pc_source), .alu_op(alu_op),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .reg_write(reg_write),
    .reg_dst(reg_dst), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,mem_to_reg,ir_write,
  //  pc_source,alu_op,alu_src_a,alu_src_b,reg_write,reg_dst,instr_done}
  function automatic logic [16:0] model(input logic [3:0] s);
    logic pw, pwc, iod, mr, mw, m2r, irw, as, rw, rd, dn;
    logic [1:0] pcs, aop, bs;
    {pw, pwc, iod, mr, mw, m2r, irw, as, rw, rd, dn} = '0;
    {pcs, aop, bs} = '0;
    case (s)
      4'd0: begin mr = 1; irw = 1; bs = 2'b01; pw = 1; end
      4'd1: bs = 2'b11;
      4'd2: begin as = 1; bs = 2'b10; end
      4'd3: begin mr = 1; iod = 1; end
      4'd4: begin rw = 1; m2r = 1; dn = 1; end
      4'd5: begin mw = 1; iod = 1; dn = 1; end
      4'd6: begin as = 1; aop = 2'b10; end
      4'd7: begin rw = 1; rd = 1; dn = 1; end
      4'd8: begin as = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; dn = 1; end
      4'd9: begin pw = 1; pcs = 2'b10; dn = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, m2r, irw, pcs, aop, as, bs, rw, rd, dn};
  endfunction

  logic [16:0] ctrl_act;
  assign ctrl_act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                     mem_to_reg, ir_write, pc_source, alu_op, alu_src_a,
                     alu_src_b, reg_write, reg_dst, instr_done};

  task automatic check(input string tag, input exp_t e);
    tests++;
    assert (state_dbg === e.st) else begin
      fails++;
      $error("FAIL %s state_dbg got %0d expected %0d", tag, state_dbg, e.st);
    end
    tests++;
    assert (ctrl_act === model(e.st)) else begin
      fails++;
      $error("FAIL %s ctrl in state %0d got %h expected %h", tag, e.st, ctrl_act, model(e.st));
    end
    tests++;
    assert (illegal_op === e.ill) else begin
      fails++;
      $error("FAIL %s illegal_op got %b expected %b", tag, illegal_op, e.ill);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic ill);
    exp_t e;
    e.st = st;
    e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    exp_t e;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      check(tag, e);
    end
  endtask

  assert property (@(negedge clk) disable iff (rst) !(mem_read && mem_write))
    else begin fails++; $error("FAIL mem_rw_excl got 1 expected 0"); end
  assert property (@(negedge clk) disable iff (rst) !(pc_write && pc_write_cond))
    else begin fails++; $error("FAIL pc_wr_excl got 1 expected 0"); end
  assert property (@(negedge clk) disable iff (rst)
                   reg_write |-> (state_dbg == 4'd4 || state_dbg == 4'd7))
    else begin fails++; $error("FAIL reg_write_state got state %0d expected 4 or 7", state_dbg); end

  initial begin
    exp_t e;
    // reset asserted mid-cycle, LW held
    #3 rst = 1'b1;
    push(4'd10, 0); push(4'd10, 0);
    drain("reset");
    #1 rst = 1'b0;

    push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(4, 0);
    drain("lw");

    opcode = 6'b101011;
    push(0, 0); push(1, 0); push(2, 0); push(5, 0);
    drain("sw");

    opcode = 6'b000000;
    push(0, 0); push(1, 0); push(6, 0); push(7, 0);
    drain("rtype");
    opcode = 6'b000100;
    push(0, 0); push(1, 0); push(8, 0);
    drain("beq");

    opcode = 6'b000010;
    push(0, 0); push(1, 0); push(9, 0);
    drain("jump");

    opcode = 6'b111111;
    push(0, 0); push(1, 0); push(0, 1);
    drain("illegal");
    opcode = 6'b100011;
    push(1, 1); push(2, 1); push(3, 1); push(4, 1);
    drain("lw_after_ill");

    push(0, 1); push(1, 1); push(2, 1); push(3, 1);
    drain("lw_pre_rst");
    #1 rst = 1'b1;
    #1;
    e.st = 4'd10; e.ill = 1'b0;
    check("async_rst", e);
    push(10, 0);
    drain("rst_hold");
    #1 rst = 1'b0;
    push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(4, 0); push(0, 0);
    drain("restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
